// File: rtl/add_nbit_seq_pkg.sv
// Shared definitions for the multi-cycle adder: FSM encoding and helpers that
// derive the chunk count and counter width from WIDTH and CHUNK.
package add_nbit_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int calc_n(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk configuration still needs a one-bit counter.
    function automatic int calc_cnt_w(input int width, input int chunk);
        int n;
        n = width / chunk;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/add_1bit.sv
// Single-bit full adder cell, reused as the building block of add_chunk.
module add_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/add_nbit_seq_chunk.sv
// Combinational CHUNK-bit ripple adder built from add_1bit cells; also exposes
// the carry into its top bit so the caller can form signed overflow.
module add_chunk #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        add_1bit u_bit (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

    assign cout  = carry[CHUNK];
    assign c_msb = carry[CHUNK-1];

endmodule

// File: rtl/add_nbit_seq.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock through a carry
// register and publishes sum/cout/ovf only when the whole word is finished.
module add_nbit_seq
    import add_nbit_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = calc_n(WIDTH, CHUNK);
    localparam int CW = calc_cnt_w(WIDTH, CHUNK);

    if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
        $error("add_nbit_seq: WIDTH must be >= 2 and divisible by CHUNK");
    end

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_next;
    logic [31:0]      idx;
    logic [CHUNK-1:0] ch_a;
    logic [CHUNK-1:0] ch_b;
    logic [CHUNK-1:0] ch_sum;
    logic             ch_cout;
    logic             ch_msb;
    logic             last;

    assign idx  = 32'(cnt) * 32'(CHUNK);
    assign ch_a = op_a[idx +: CHUNK];
    assign ch_b = op_b[idx +: CHUNK];
    assign last = (cnt == CW'(N - 1));
    assign busy = (state == RUN);

    add_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a     (ch_a),
        .b     (ch_b),
        .cin   (carry),
        .sum   (ch_sum),
        .cout  (ch_cout),
        .c_msb (ch_msb)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        work_next = work;
        work_next[idx +: CHUNK] = ch_sum;
    end

    // On the final chunk the carry out of the chunk adder is the word's carry
    // out, and its c_msb is the carry into the word's MSB.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            carry <= 1'b0;
            op_a  <= '0;
            op_b  <= '0;
            work  <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    work  <= work_next;
                    carry <= ch_cout;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        cnt  <= '0;
                        sum  <= work_next;
                        cout <= ch_cout;
                        ovf  <= ch_cout ^ ch_msb;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/add_nbit_seq.md
# add_nbit_seq

Parametrised multi-cycle adder/subtractor, the successor to the single-bit `add_1bit` cell. It adds two WIDTH-bit operands plus carry-in, or subtracts them, processing CHUNK bits per clock through a carry register. It uses a start/busy/done handshake and holds its result until the next operation completes. It sits beside `add_1bit` as the arithmetic block for datapaths that trade latency for area.

## Interface

**Parameters**
- `WIDTH`, default 8: operand and result width. Must be at least 2.
- `CHUNK`, default 2: bits processed per cycle. WIDTH must be divisible by CHUNK. N = WIDTH/CHUNK cycles per operation.

**Ports**
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state and outputs.
- `start` in 1: request. Sampled only when `busy`=0.
- `sub` in 1: 0 = a+b+cin; 1 = a-b, computed as a+~b+1 with `cin` ignored. Captured at start.
- `a` in WIDTH: operand A, captured at the accepted start.
- `b` in WIDTH: operand B, captured at the accepted start.
- `cin` in 1: carry-in for add mode, captured at start.
- `busy` out 1: high while an operation is in progress.
- `done` out 1: one-cycle pulse when the result registers update.
- `sum` out WIDTH: result, held between operations.
- `cout` out 1: carry out of MSB. In sub mode, 1 means no borrow.
- `ovf` out 1: signed overflow = carry into MSB XOR carry out of MSB.

## Operation

**States:** IDLE and RUN. A chunk counter runs 0..N-1, and a carry register holds the carry between chunks.

**IDLE**
- If `start`=1, capture the following:
  - `a` and `b`, with b inverted when `sub`=1;
  - carry register = `sub` ? 1 : `cin`;
  - counter = 0.
- Then go to RUN and set `busy`=1.

**RUN, each cycle**
- Add chunk[counter] of A and B with the carry register through the chunk adder.
- Write the CHUNK sum bits into the working sum register at that position.
- Update the carry register; latch carry-into-MSB when counter = N-1.
- Increment the counter.

**After chunk N-1**
- Copy the working sum into `sum`; load `cout` and `ovf`.
- Pulse `done`=1, set `busy`=0, return to IDLE.

**Other rules**
- `start` while `busy`=1 is ignored, with no queuing.
- Input changes during RUN have no effect.
- Output hold: `sum`, `cout` and `ovf` change only on a completing edge or on reset. They never show partial results.
- Arithmetic is unsigned modulo 2^WIDTH. `ovf` is meaningful for two's-complement interpretation only.

## Timing

- Reset values: `busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0, state IDLE, counter 0, carry 0.
- Reset mid-operation discards the partial result immediately and asynchronously. The first `start` after reset deasserts is accepted normally.
- Latency:
  - `start` sampled high at edge k;
  - `busy` is high after edge k through edge k+N;
  - `done` and the new result are visible after edge k+N.
  - With WIDTH=8, CHUNK=2, that is 4 cycles.
- Throughput: `start` asserted in the `done` cycle is accepted at edge k+N+1, giving one operation per N+1 cycles.
- `done` is exactly one cycle wide and never coincides with `busy`=1.
- When CHUNK=WIDTH (N=1), the operation completes one edge after start.

## Structure

- Shared package/header holds:
  - the state encodings (IDLE=0, RUN=1);
  - a localparam function computing N and the counter width, clog2(N) with a minimum of 1.
- The parameter check (WIDTH % CHUNK == 0) is an elaboration-time assertion.
- One sub-module, `add_chunk`: combinational CHUNK-bit ripple adder built from CHUNK `add_1bit` instances.
  - Ports: a[CHUNK], b[CHUNK], cin, sum[CHUNK], cout, c_msb (carry into the top bit).
- The top level holds the FSM, counter, carry register, operand/working registers and output registers.

## Test plan

All scenarios use WIDTH=8, CHUNK=2.

1. a=8'h0F, b=8'h01, cin=0, sub=0, start 1 cycle -> `done` pulses exactly 4 edges later; sum=8'h10, cout=0, ovf=0; `busy` high for 4 cycles.
2. a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0. Then a=8'h7F, b=8'h00, cin=1 -> sum=8'h80, cout=0, ovf=1.
3. sub=1, a=8'h05, b=8'h07, cin=1 (ignored) -> sum=8'hFE, cout=0, ovf=0. Then a=8'h80, b=8'h01 -> sum=8'h7F, cout=1, ovf=1.
4. Start A with a=8'h10, b=8'h20. Pulse `start` with a different a and b during RUN -> ignored; result 8'h30; only one `done`.
5. Assert `reset` on the 2nd RUN cycle of an operation -> busy=0, done=0, sum=0, cout=0, ovf=0 immediately. Release reset, then start a=8'h03, b=8'h04 -> sum=8'h07 after 4 cycles.
6. Back-to-back: hold `start` high with new operands during the `done` cycle -> accepted, next `done` 5 edges after the previous one. The previous `sum` stays stable until then.
